// File: rtl/perf_counter_bank.sv
// perf_counter_bank: masked, run/freeze-gated event counters with an
// optional bounded window, sticky overflow flags and a registered read port.
// Ports: clk, rst (async, active-low), test_enable, event_i, en_mask,
//   start/stop/clear/snap pulses, window_len, rd_en, rd_addr
//   -> rd_data, rd_valid, running, window_done.
// Optional feature macro: PERF_SNAPSHOT_EN (counter/overflow reads come
//   from shadow copies captured on snap).
module perf_counter_bank #(
  parameter int NUM_EVENTS = 16,
  parameter int CNT_W      = 32,
  parameter bit SATURATE   = 1'b0,
  parameter int AW         = $clog2(NUM_EVENTS+2)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  test_enable,
  input  logic [NUM_EVENTS-1:0] event_i,
  input  logic [NUM_EVENTS-1:0] en_mask,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic [CNT_W-1:0]      window_len,
  input  logic                  snap,
  input  logic                  rd_en,
  input  logic [AW-1:0]         rd_addr,
  output logic [CNT_W-1:0]      rd_data,
  output logic                  rd_valid,
  output logic                  running,
  output logic                  window_done
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FROZEN = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q [NUM_EVENTS];
  logic [CNT_W-1:0]      cnt_d [NUM_EVENTS];
  logic [NUM_EVENTS-1:0] ovf_q, ovf_d;
  logic [CNT_W-1:0]      win_rem_q, win_rem_d;
  logic [CNT_W-1:0]      rd_data_q, rd_data_d;
  logic                  rd_valid_q;
  logic                  running_q, running_d;
  logic                  wdone_q, wdone_d;

  logic                  counting;
  logic                  win_on;
  logic                  expire;
  logic [NUM_EVENTS-1:0] hit;
  logic [CNT_W-1:0]      status;
  logic [CNT_W-1:0]      rd_cnt [NUM_EVENTS];
  logic [NUM_EVENTS-1:0] rd_ovf;

  assign counting = (state_q == ST_RUN) && test_enable;
  // A nonzero remainder means a bounded window is pending.
  assign win_on   = (win_rem_q != '0);
  assign expire   = counting && (win_rem_q == CNT_W'(1));
  assign hit      = event_i & en_mask & {NUM_EVENTS{counting}};

  // Command priority: clear, stop, window expiry, start.
  always_comb begin
    state_d   = state_q;
    win_rem_d = win_rem_q;
    wdone_d   = 1'b0;
    if (counting && win_on)
      win_rem_d = win_rem_q - CNT_W'(1);
    priority case (1'b1)
      clear: begin
        state_d   = ST_IDLE;
        win_rem_d = '0;
      end
      stop: begin
        wdone_d = expire;
        if (state_q == ST_RUN)
          state_d = ST_FROZEN;
      end
      expire: begin
        wdone_d = 1'b1;
        state_d = ST_FROZEN;
      end
      (start && state_q != ST_RUN): begin
        state_d   = ST_RUN;
        win_rem_d = window_len;
      end
      default: ;
    endcase
    running_d = (state_d == ST_RUN);
  end

  always_comb begin
    ovf_d = ovf_q;
    for (int k = 0; k < NUM_EVENTS; k++) begin
      cnt_d[k] = cnt_q[k];
      if (clear) begin
        cnt_d[k] = '0;
      end else if (hit[k]) begin
        if (&cnt_q[k]) begin
          ovf_d[k] = 1'b1;
          cnt_d[k] = SATURATE ? cnt_q[k] : '0;
        end else begin
          cnt_d[k] = cnt_q[k] + CNT_W'(1);
        end
      end
    end
    if (clear)
      ovf_d = '0;
  end

`ifdef PERF_SNAPSHOT_EN
  logic [CNT_W-1:0]      sh_q [NUM_EVENTS];
  logic [CNT_W-1:0]      sh_d [NUM_EVENTS];
  logic [NUM_EVENTS-1:0] sh_ovf_q, sh_ovf_d;

  // Shadows take pre-increment values; clear wins over snap.
  always_comb begin
    sh_ovf_d = sh_ovf_q;
    for (int k = 0; k < NUM_EVENTS; k++)
      sh_d[k] = sh_q[k];
    if (clear) begin
      sh_ovf_d = '0;
      for (int k = 0; k < NUM_EVENTS; k++)
        sh_d[k] = '0;
    end else if (snap) begin
      sh_ovf_d = ovf_q;
      for (int k = 0; k < NUM_EVENTS; k++)
        sh_d[k] = cnt_q[k];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_ovf_q <= '0;
      for (int k = 0; k < NUM_EVENTS; k++)
        sh_q[k] <= '0;
    end else begin
      sh_ovf_q <= sh_ovf_d;
      for (int k = 0; k < NUM_EVENTS; k++)
        sh_q[k] <= sh_d[k];
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_EVENTS; k++)
      rd_cnt[k] = sh_q[k];
  end
  assign rd_ovf = sh_ovf_q;
`else
  logic unused_snap;
  assign unused_snap = snap;

  always_comb begin
    for (int k = 0; k < NUM_EVENTS; k++)
      rd_cnt[k] = cnt_q[k];
  end
  assign rd_ovf = ovf_q;
`endif

  // Status is always live, even when counters read from shadows.
  always_comb begin
    status      = '0;
    status[1:0] = state_q;
    status[2]   = win_on;
    status[3]   = |ovf_q;
    rd_data_d   = '0;
    if (rd_en) begin
      if (rd_addr == AW'(NUM_EVENTS))
        rd_data_d = CNT_W'(rd_ovf);
      else if (rd_addr == AW'(NUM_EVENTS + 1))
        rd_data_d = status;
      for (int k = 0; k < NUM_EVENTS; k++)
        if (rd_addr == AW'(k))
          rd_data_d = rd_cnt[k];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      ovf_q      <= '0;
      win_rem_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      running_q  <= 1'b0;
      wdone_q    <= 1'b0;
      for (int k = 0; k < NUM_EVENTS; k++)
        cnt_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      ovf_q      <= ovf_d;
      win_rem_q  <= win_rem_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_en;
      running_q  <= running_d;
      wdone_q    <= wdone_d;
      for (int k = 0; k < NUM_EVENTS; k++)
        cnt_q[k] <= cnt_d[k];
    end
  end

  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign running     = running_q;
  assign window_done = wdone_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// tb_perf_counter_bank: drives a wrapping and a saturating bank in parallel
// and compares both against an arithmetic model plus literal expectations.
module tb_perf_counter_bank;
  localparam int NE   = 4;
  localparam int CW   = 4;
  localparam int AW   = 3;
  localparam int MAXV = (1 << CW) - 1;
`ifdef PERF_SNAPSHOT_EN
  localparam bit SNAP_MODE = 1'b1;
`else
  localparam bit SNAP_MODE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic test_enable = 1'b1;
  logic start = 1'b0, stop = 1'b0, clear = 1'b0;
  logic snap = 1'b0, rd_en = 1'b0;
  logic [NE-1:0] event_i = '0, en_mask = '0;
  logic [CW-1:0] window_len = '0;
  logic [AW-1:0] rd_addr = '0;

  logic [CW-1:0] rdata [2];
  logic rvalid [2];
  logic run_o [2];
  logic wdone [2];

  perf_counter_bank #(.NUM_EVENTS(NE), .CNT_W(CW), .SATURATE(1'b0), .AW(AW))
  u_wrap (
    .clk(clk), .rst(rst), .test_enable(test_enable),
    .event_i(event_i), .en_mask(en_mask),
    .start(start), .stop(stop), .clear(clear),
    .window_len(window_len), .snap(snap),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rdata[0]), .rd_valid(rvalid[0]),
    .running(run_o[0]), .window_done(wdone[0])
  );

  perf_counter_bank #(.NUM_EVENTS(NE), .CNT_W(CW), .SATURATE(1'b1), .AW(AW))
  u_sat (
    .clk(clk), .rst(rst), .test_enable(test_enable),
    .event_i(event_i), .en_mask(en_mask),
    .start(start), .stop(stop), .clear(clear),
    .window_len(window_len), .snap(snap),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rdata[1]), .rd_valid(rvalid[1]),
    .running(run_o[1]), .window_done(wdone[1])
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, want, $time);
    end
  endtask

  // ---------------- model ----------------
  int m_cnt [2][NE];
  bit m_ovf [2][NE];
  int m_sh  [2][NE];
  bit m_sho [2][NE];
  int m_state = 0;
  int m_win = 0;
  bit e_rv = 0, e_run = 0, e_wd = 0;
  int e_rd [2];

  task automatic model_clear();
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < NE; k++) begin
        m_cnt[i][k] = 0; m_ovf[i][k] = 0;
        m_sh[i][k] = 0;  m_sho[i][k] = 0;
      end
    m_state = 0;
    m_win = 0;
  endtask

  function automatic int m_read(int i, int a);
    int v = 0;
    if (a < NE) begin
      v = SNAP_MODE ? m_sh[i][a] : m_cnt[i][a];
    end else if (a == NE) begin
      for (int k = 0; k < NE; k++)
        if (SNAP_MODE ? m_sho[i][k] : m_ovf[i][k]) v += (1 << k);
    end else if (a == NE + 1) begin
      v = m_state;
      if (m_win != 0) v += 4;
      for (int k = 0; k < NE; k++)
        if (m_ovf[i][k]) v = v | 8;
    end
    return v;
  endfunction

  always @(negedge rst) begin
    model_clear();
    e_rv = 0; e_run = 0; e_wd = 0;
    e_rd[0] = 0; e_rd[1] = 0;
  end

  always @(posedge clk) begin : mdl
    bit counting;
    bit expired;
    if (rst) begin
      e_rv = rd_en;
      for (int i = 0; i < 2; i++)
        e_rd[i] = rd_en ? m_read(i, int'(rd_addr)) : 0;
      counting = (m_state == 1) && test_enable;
      expired = counting && (m_win == 1);
      e_wd = 0;
      if (clear) begin
        model_clear();
      end else begin
        for (int i = 0; i < 2; i++)
          for (int k = 0; k < NE; k++) begin
            if (snap) begin
              m_sh[i][k] = m_cnt[i][k];
              m_sho[i][k] = m_ovf[i][k];
            end
            if (counting && event_i[k] && en_mask[k]) begin
              if (m_cnt[i][k] == MAXV) begin
                m_ovf[i][k] = 1;
                m_cnt[i][k] = (i == 1) ? MAXV : 0;
              end else begin
                m_cnt[i][k] = m_cnt[i][k] + 1;
              end
            end
          end
        if (counting && m_win != 0) m_win = m_win - 1;
        e_wd = expired;
        if (stop) begin
          if (m_state == 1) m_state = 2;
        end else if (expired) begin
          m_state = 2;
        end else if (start && m_state != 1) begin
          m_state = 1;
          m_win = int'(window_len);
        end
      end
      e_run = (m_state == 1);
    end
  end

  bit cmp_on = 0;
  always @(negedge clk) begin
    if (cmp_on) begin
      for (int i = 0; i < 2; i++) begin
        check("cyc_rd_valid", 32'(rvalid[i]), 32'(e_rv));
        check("cyc_running", 32'(run_o[i]), 32'(e_run));
        check("cyc_window_done", 32'(wdone[i]), 32'(e_wd));
        if (e_rv) check("cyc_rd_data", 32'(rdata[i]), e_rd[i]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd_chk(input string nm, input int a, input int e0,
                        input int e1);
    rd_addr = AW'(a);
    rd_en = 1'b1;
    cyc(1);
    rd_en = 1'b0;
    check({nm, "_wrap"}, 32'(rdata[0]), e0);
    check({nm, "_sat"}, 32'(rdata[1]), e1);
  endtask

  task automatic snap_rd(input string nm, input int a, input int e0,
                         input int e1);
    snap = 1'b1;
    cyc(1);
    snap = 1'b0;
    rd_chk(nm, a, e0, e1);
  endtask

  task automatic go();
    start = 1'b1; cyc(1); start = 1'b0;
  endtask

  task automatic halt();
    stop = 1'b1; cyc(1); stop = 1'b0;
  endtask

  task automatic clr();
    clear = 1'b1; cyc(1); clear = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench exceeded time budget");
    $fatal(1);
  end

  initial begin
    int wd;
    cyc(3);
    for (int i = 0; i < 2; i++) begin
      check("reset_rd_data", 32'(rdata[i]), 0);
      check("reset_rd_valid", 32'(rvalid[i]), 0);
      check("reset_running", 32'(run_o[i]), 0);
      check("reset_window_done", 32'(wdone[i]), 0);
    end
    rst = 1'b1;
    cmp_on = 1;
    cyc(1);
    rd_chk("status_after_reset", NE + 1, 0, 0);

    // mask and test_enable gating
    en_mask = 4'b0101;
    go();
    check("running_after_start", 32'(run_o[0]), 1);
    event_i = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      test_enable = !(c >= 3 && c < 6);
      cyc(1);
    end
    test_enable = 1'b1;
    event_i = '0;
    halt();
    snap_rd("mask_ch0", 0, 7, 7);
    snap_rd("mask_ch1", 1, 0, 0);
    snap_rd("mask_ch2", 2, 7, 7);
    snap_rd("mask_ch3", 3, 0, 0);
    rd_chk("mask_status", NE + 1, 2, 2);

    // bounded window, then resume
    clr();
    en_mask = '1;
    window_len = 4'd5;
    go();
    event_i = 4'b0001;
    wd = 0;
    repeat (10) begin
      cyc(1);
      if (wdone[0]) wd++;
    end
    event_i = '0;
    check("window_done_pulses", wd, 1);
    rd_chk("window_status", NE + 1, 2, 2);
    snap_rd("window_ch0", 0, 5, 5);
    window_len = '0;
    go();
    event_i = 4'b0001;
    cyc(3);
    event_i = '0;
    halt();
    snap_rd("resume_ch0", 0, 8, 8);

    // overflow: wrap vs saturate
    clr();
    en_mask = 4'b0001;
    go();
    event_i = 4'b0001;
    cyc(15);
    event_i = '0;
    snap_rd("ovf_pre_ch0", 0, 15, 15);
    rd_chk("ovf_pre_flags", NE, 0, 0);
    event_i = 4'b0001;
    cyc(1);
    event_i = '0;
    snap_rd("ovf_ch0", 0, 0, 15);
    rd_chk("ovf_flags", NE, 1, 1);
    rd_chk("ovf_status", NE + 1, 9, 9);
    clr();
    snap_rd("clr_ch0", 0, 0, 0);
    rd_chk("clr_flags", NE, 0, 0);
    rd_chk("clr_status", NE + 1, 0, 0);

    // command priority
    en_mask = '1;
    go();
    event_i = 4'b0001;
    cyc(2);
    event_i = '0;
    start = 1'b1; stop = 1'b1; clear = 1'b1;
    cyc(1);
    start = 1'b0; stop = 1'b0; clear = 1'b0;
    rd_chk("prio_all_status", NE + 1, 0, 0);
    snap_rd("prio_all_ch0", 0, 0, 0);
    go();
    event_i = 4'b0001;
    cyc(2);
    event_i = '0;
    start = 1'b1; stop = 1'b1;
    cyc(1);
    start = 1'b0; stop = 1'b0;
    rd_chk("prio_stop_status", NE + 1, 2, 2);
    snap_rd("prio_ch0", 0, 2, 2);
    rd_addr = '0; rd_en = 1'b1; clear = 1'b1;
    cyc(1);
    rd_en = 1'b0; clear = 1'b0;
    check("read_with_clear", 32'(rdata[0]), 2);
    snap_rd("after_clear_ch0", 0, 0, 0);

    // snapshot behaviour
    go();
    event_i = 4'b0001;
    cyc(8);
    event_i = '0;
    snap = 1'b1; cyc(1); snap = 1'b0;
    event_i = 4'b0001;
    cyc(4);
    event_i = '0;
    rd_chk("snap_first", 0, SNAP_MODE ? 8 : 12, SNAP_MODE ? 8 : 12);
    snap_rd("snap_second", 0, 12, 12);
    clear = 1'b1; snap = 1'b1;
    cyc(1);
    clear = 1'b0; snap = 1'b0;
    rd_chk("snap_with_clear", 0, 0, 0);

    // asynchronous reset mid-run
    go();
    event_i = 4'b0001;
    rd_addr = '0;
    rd_en = 1'b1;
    cyc(2);
    #2 rst = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("async_rd_data", 32'(rdata[i]), 0);
      check("async_rd_valid", 32'(rvalid[i]), 0);
      check("async_running", 32'(run_o[i]), 0);
      check("async_window_done", 32'(wdone[i]), 0);
    end
    rd_en = 1'b0;
    event_i = '0;
    cyc(2);
    rst = 1'b1;
    cyc(1);
    rd_chk("post_reset_status", NE + 1, 0, 0);
    snap_rd("post_reset_ch0", 0, 0, 0);

    cyc(2);
    cmp_on = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
